// File: rtl/vga_pkg.sv
// Shared VGA constants and the per-sprite configuration record used by the
// timing generator and the sprite engine.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int COLOR_W = 12;
  localparam logic [COLOR_W-1:0] BG_COLOR  = 12'h000;
  localparam logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F;

  localparam int CNT_W  = 10;
  // Base is held at full width so any ROM address width up to 32 fits.
  localparam int BASE_W = 32;

  typedef struct packed {
    logic              en;
    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    logic [BASE_W-1:0] base;
  } sprite_cfg_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel-slot divider, horizontal/vertical counters, sync/active decode and the
// frame-boundary (shadow copy) strobe.
module vga_timing #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE_D,
  parameter int H_FP     = vga_pkg::H_FP_D,
  parameter int H_SYNC   = vga_pkg::H_SYNC_D,
  parameter int H_BP     = vga_pkg::H_BP_D,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE_D,
  parameter int V_FP     = vga_pkg::V_FP_D,
  parameter int V_SYNC   = vga_pkg::V_SYNC_D,
  parameter int V_BP     = vga_pkg::V_BP_D,
  parameter int PIX_DIV  = 4,
  localparam int SLOT_W  = $clog2(PIX_DIV)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [SLOT_W-1:0]         slot,
  output logic                      pe,
  output logic [vga_pkg::CNT_W-1:0] hc,
  output logic [vga_pkg::CNT_W-1:0] vc,
  output logic                      hsync_n,
  output logic                      vsync_n,
  output logic                      active,
  output logic                      copy,
  output logic                      frame_start
);
  import vga_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0]  H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]  H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]  V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0]  HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0]  VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0]  VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SLOT_W-1:0] PE_SLOT    = SLOT_W'(PIX_DIV - 1);

  logic [SLOT_W-1:0] slot_reg;
  logic [CNT_W-1:0]  hc_reg;
  logic [CNT_W-1:0]  vc_reg;
  logic              frame_start_reg;

  assign slot        = slot_reg;
  assign hc          = hc_reg;
  assign vc          = vc_reg;
  assign pe          = (slot_reg == PE_SLOT);
  assign hsync_n     = !((hc_reg >= HS_START) && (hc_reg < HS_END));
  assign vsync_n     = !((vc_reg >= VS_START) && (vc_reg < VS_END));
  assign active      = (hc_reg < H_ACT) && (vc_reg < V_ACT);
  // True on the pixel edge that moves the scan to (0, V_ACTIVE).
  assign copy        = pe && (hc_reg == H_LAST) && (vc_reg == V_ACT_LAST);
  assign frame_start = frame_start_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_reg        <= '0;
      hc_reg          <= '0;
      vc_reg          <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= copy;
      if (pe) begin
        slot_reg <= '0;
        if (hc_reg == H_LAST) begin
          hc_reg <= '0;
          vc_reg <= (vc_reg == V_LAST) ? '0 : vc_reg + 1'b1;
        end else begin
          hc_reg <= hc_reg + 1'b1;
        end
      end else begin
        slot_reg <= slot_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_sprite_engine.sv
// VGA sprite compositor: shadowed sprite register file, time-multiplexed ROM
// fetch per pixel slot, priority/transparency compositing and output register.
module vga_sprite_engine #(
  parameter int H_ACTIVE  = vga_pkg::H_ACTIVE_D,
  parameter int H_FP      = vga_pkg::H_FP_D,
  parameter int H_SYNC    = vga_pkg::H_SYNC_D,
  parameter int H_BP      = vga_pkg::H_BP_D,
  parameter int V_ACTIVE  = vga_pkg::V_ACTIVE_D,
  parameter int V_FP      = vga_pkg::V_FP_D,
  parameter int V_SYNC    = vga_pkg::V_SYNC_D,
  parameter int V_BP      = vga_pkg::V_BP_D,
  parameter int PIX_DIV   = 4,
  parameter int N_SPRITES = 3,
  parameter int SPR_W     = 64,
  parameter int SPR_H     = 64,
  parameter int ADDR_W    = 17,
  parameter int COLOR_W   = vga_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR  = vga_pkg::BG_COLOR,
  parameter logic [COLOR_W-1:0] KEY_COLOR = vga_pkg::KEY_COLOR,
  localparam int SEL_W  = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
  localparam int SLOT_W = $clog2(PIX_DIV)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic               cfg_en,
  input  logic [9:0]         cfg_x,
  input  logic [9:0]         cfg_y,
  input  logic [ADDR_W-1:0]  cfg_base,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0] rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               valid,
  output logic [9:0]         h_cnt,
  output logic [9:0]         v_cnt,
  output logic               frame_start
);
  import vga_pkg::*;

  logic [SLOT_W-1:0] slot;
  logic              pe;
  logic [CNT_W-1:0]  hc;
  logic [CNT_W-1:0]  vc;
  logic              hsync_n;
  logic              vsync_n;
  logic              active;
  logic              copy;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .PIX_DIV  (PIX_DIV)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .slot        (slot),
    .pe          (pe),
    .hc          (hc),
    .vc          (vc),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .active      (active),
    .copy        (copy),
    .frame_start (frame_start)
  );

  sprite_cfg_t pend_reg [N_SPRITES];
  sprite_cfg_t act_reg  [N_SPRITES];

  // Active copy takes the pre-write pending value when a write lands on the copy edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        pend_reg[i] <= '0;
        act_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_SPRITES; i++) begin
        if (copy)
          act_reg[i] <= pend_reg[i];
        if (cfg_we && (int'(cfg_sel) == i))
          pend_reg[i] <= '{en: cfg_en, x: cfg_x, y: cfg_y, base: BASE_W'(cfg_base)};
      end
    end
  end

  logic              hit_vec  [N_SPRITES];
  logic [ADDR_W-1:0] addr_vec [N_SPRITES];

  // 11-bit compares so x+SPR_W past the line end never wraps back to column 0.
  for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_spr
    logic [10:0] hc11, vc11, x11, y11, dx, dy;
    logic [31:0] offset;
    assign hc11   = {1'b0, hc};
    assign vc11   = {1'b0, vc};
    assign x11    = {1'b0, act_reg[gi].x};
    assign y11    = {1'b0, act_reg[gi].y};
    assign dx     = hc11 - x11;
    assign dy     = vc11 - y11;
    assign offset = 32'(dy) * 32'(SPR_W) + 32'(dx);
    assign hit_vec[gi] = act_reg[gi].en
                      && (hc11 >= x11) && (hc11 < x11 + 11'(SPR_W))
                      && (vc11 >= y11) && (vc11 < y11 + 11'(SPR_H));
    assign addr_vec[gi] = ADDR_W'(act_reg[gi].base + offset);
  end

  logic              hit;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] rom_addr_reg;

  always_comb begin
    hit        = 1'b0;
    fetch_addr = addr_vec[0];
    for (int i = 0; i < N_SPRITES; i++) begin
      if (int'(slot) == i) begin
        hit        = hit_vec[i];
        fetch_addr = addr_vec[i];
      end
    end
  end

  // Address is presented during the sprite's own slot so data returns in the next.
  assign rom_addr = hit ? fetch_addr : rom_addr_reg;

  logic               hit_prev_reg;
  logic               won_reg;
  logic [COLOR_W-1:0] acc_reg;
  logic               take;
  logic [COLOR_W-1:0] acc_next;

  assign take     = (slot != '0) && hit_prev_reg && (rom_data != KEY_COLOR) && !won_reg;
  assign acc_next = take ? rom_data : acc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr_reg <= '0;
      hit_prev_reg <= 1'b0;
      won_reg      <= 1'b0;
      acc_reg      <= BG_COLOR;
    end else begin
      rom_addr_reg <= rom_addr;
      hit_prev_reg <= hit;
      if (slot == '0) begin
        acc_reg <= BG_COLOR;
        won_reg <= 1'b0;
      end else begin
        acc_reg <= acc_next;
        won_reg <= won_reg | take;
      end
    end
  end

  // The last slot's ROM result is folded in combinationally on the pixel edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb   <= '0;
      valid <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pe) begin
      rgb   <= active ? acc_next : '0;
      valid <= active;
      hsync <= hsync_n;
      vsync <= vsync_n;
      h_cnt <= hc;
      v_cnt <= vc;
    end
  end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine on a shrunken 40x16 raster with 8x8 sprites.
module tb_vga_sprite_engine;

  localparam int HA = 40, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 16, VFP = 1, VS = 2, VBP = 1;
  localparam int PD = 4, NS = 3, SW = 8, SH = 8, AW = 12, CW = 12;
  localparam int FRAME_CLKS = (HA + HFP + HS + HBP) * (VA + VFP + VS + VBP) * PD;
  localparam int BUDGET = 10000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic          cfg_en;
  logic [9:0]    cfg_x, cfg_y;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] rom_data;
  logic [CW-1:0] rgb;
  logic          hsync, vsync, valid, frame_start;
  logic [9:0]    h_cnt, v_cnt;

  logic [CW-1:0] rom_mem [1 << AW];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  vga_sprite_engine #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .PIX_DIV (PD), .N_SPRITES (NS), .SPR_W (SW), .SPR_H (SH),
    .ADDR_W (AW), .COLOR_W (CW), .BG_COLOR (12'h000), .KEY_COLOR (12'hF0F)
  ) dut (
    .clk (clk), .rst (rst),
    .cfg_we (cfg_we), .cfg_sel (cfg_sel), .cfg_en (cfg_en),
    .cfg_x (cfg_x), .cfg_y (cfg_y), .cfg_base (cfg_base),
    .rom_addr (rom_addr), .rom_data (rom_data),
    .rgb (rgb), .hsync (hsync), .vsync (vsync), .valid (valid),
    .h_cnt (h_cnt), .v_cnt (v_cnt), .frame_start (frame_start)
  );

  task automatic cfg_write(input int sel, input bit en, input int x, input int y, input int base);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_en = en;
    cfg_x = 10'(x); cfg_y = 10'(y); cfg_base = AW'(base);
    @(negedge clk);
    cfg_we = 1'b0;
    $display("cfg sel=%0d en=%0d x=%0d y=%0d base=%0d", sel, en, x, y, base);
  endtask

  task automatic wait_out(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (h_cnt == 10'(h) && v_cnt == 10'(v)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_pixel (%0d,%0d) not reached got (%0d,%0d)", h, v, h_cnt, v_cnt);
    end
  endtask

  task automatic wait_fs();
    bit ok = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_frame_start timeout got 0 want 1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({hsync, vsync} !== 2'b11) begin
      errors++; $display("FAIL reset_sync got %b want 11", {hsync, vsync});
    end
    checks++;
    if ({valid, frame_start, rgb} !== 14'h0) begin
      errors++; $display("FAIL reset_rgb valid=%b fs=%b rgb=%h want 0 0 000", valid, frame_start, rgb);
    end
    checks++;
    if ({h_cnt, v_cnt, rom_addr} !== 32'h0) begin
      errors++; $display("FAIL reset_cnt h=%0d v=%0d addr=%0d want 0 0 0", h_cnt, v_cnt, rom_addr);
    end
    $display("reset held: hsync=%b vsync=%b rgb=%h", hsync, vsync, rgb);
  endtask

  task automatic test_timing();
    int hs_low = 0, vs_low = 0, val_hi = 0, fs_cnt = 0;
    rst = 1'b1;
    for (int n = 0; n < FRAME_CLKS; n++) begin
      @(negedge clk);
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (valid) val_hi++;
      if (frame_start) fs_cnt++;
    end
    checks++;
    if (hs_low != HS * PD * (VA + VFP + VS + VBP)) begin
      errors++; $display("FAIL hsync_low_clks got %0d want %0d", hs_low, HS * PD * 20);
    end
    checks++;
    if (vs_low != VS * (HA + HFP + HS + HBP) * PD) begin
      errors++; $display("FAIL vsync_low_clks got %0d want %0d", vs_low, VS * 48 * PD);
    end
    checks++;
    if (val_hi != HA * VA * PD) begin
      errors++; $display("FAIL valid_clks got %0d want %0d", val_hi, HA * VA * PD);
    end
    checks++;
    if (fs_cnt != 1) begin
      errors++; $display("FAIL frame_start_pulses got %0d want 1", fs_cnt);
    end
    $display("frame: hsync_low=%0d vsync_low=%0d valid=%0d fs=%0d", hs_low, vs_low, val_hi, fs_cnt);
  endtask

  task automatic test_single();
    int            th [7] = '{9, 10, 17, 18, 10, 17, 10};
    int            tv [7] = '{5, 5, 5, 5, 6, 12, 13};
    logic [CW-1:0] te [7] = '{12'd0, 12'd0, 12'd7, 12'd0, 12'd8, 12'd63, 12'd0};
    bit ok;
    cfg_write(0, 1'b1, 10, 5, 0);
    wait_fs();
    for (int i = 0; i < 7; i++) begin
      wait_out(th[i], tv[i], ok);
      if (ok) begin
        checks++;
        if (rgb !== te[i]) begin
          errors++; $display("FAIL single (%0d,%0d) rgb got %h want %h", th[i], tv[i], rgb, te[i]);
        end
        $display("single (%0d,%0d) rgb=%h", th[i], tv[i], rgb);
      end
    end
  endtask

  task automatic test_shadow();
    int            th [6] = '{11, 26, 11, 26, 26, 31};
    logic [CW-1:0] te [6] = '{12'd1, 12'd0, 12'd0, 12'd1, 12'd0, 12'd1};
    bit ok;
    wait_out(10, 3, ok);
    cfg_write(0, 1'b1, 25, 5, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        // Drive a write exactly on the copy edge: the last clk of output pixel (46,15).
        wait_out(46, 15, ok);
        repeat (3) @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_en = 1'b1;
        cfg_x = 10'd30; cfg_y = 10'd5; cfg_base = '0;
        @(negedge clk);
        cfg_we = 1'b0;
        checks++;
        if ({frame_start, h_cnt, v_cnt} !== {1'b1, 10'd47, 10'd15}) begin
          errors++;
          $display("FAIL copy_cycle fs=%b at (%0d,%0d) want 1 at (47,15)", frame_start, h_cnt, v_cnt);
        end
        $display("copy-cycle write x=30: fs=%b at (%0d,%0d)", frame_start, h_cnt, v_cnt);
      end
      if (i == 4) wait_fs();
      wait_out(th[i], 5, ok);
      if (ok) begin
        checks++;
        if (rgb !== te[i]) begin
          errors++; $display("FAIL shadow[%0d] (%0d,5) rgb got %h want %h", i, th[i], rgb, te[i]);
        end
        $display("shadow[%0d] (%0d,5) rgb=%h", i, th[i], rgb);
      end
    end
  endtask

  task automatic test_priority();
    int            th [5] = '{28, 29, 36, 30, 32};
    int            tv [5] = '{8, 9, 9, 10, 12};
    logic [CW-1:0] te [5] = '{12'h0A0, 12'h0A0, 12'h00C, 12'h0A0, 12'h123};
    bit ok;
    for (int a = 0; a < SW * SH; a++) begin
      rom_mem[1024 + a] = 12'hF0F;
      rom_mem[2048 + a] = 12'h0A0;
      rom_mem[3072 + a] = 12'h00C;
    end
    cfg_write(0, 1'b1, 30, 10, 1024);
    cfg_write(1, 1'b1, 28, 8, 2048);
    cfg_write(2, 1'b1, 29, 9, 3072);
    wait_fs();
    for (int i = 0; i < 5; i++) begin
      if (i == 4)
        for (int a = 0; a < SW * SH; a++) rom_mem[1024 + a] = 12'h123;
      wait_out(th[i], tv[i], ok);
      if (ok) begin
        checks++;
        if (rgb !== te[i]) begin
          errors++; $display("FAIL priority (%0d,%0d) rgb got %h want %h", th[i], tv[i], rgb, te[i]);
        end
        $display("priority (%0d,%0d) rgb=%h", th[i], tv[i], rgb);
      end
    end
  endtask

  task automatic test_clip();
    int            th [5] = '{37, 39, 40, 1, 37};
    int            tv [5] = '{2, 2, 2, 3, 3};
    logic [CW-1:0] te [5] = '{12'd1, 12'd3, 12'd0, 12'd0, 12'd9};
    logic          tval [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bit ok;
    cfg_write(1, 1'b0, 0, 0, 0);
    cfg_write(2, 1'b0, 0, 0, 0);
    cfg_write(0, 1'b1, 36, 2, 0);
    wait_fs();
    for (int i = 0; i < 5; i++) begin
      wait_out(th[i], tv[i], ok);
      if (ok) begin
        checks++;
        if ({valid, rgb} !== {tval[i], te[i]}) begin
          errors++;
          $display("FAIL clip (%0d,%0d) valid=%b rgb=%h want %b %h", th[i], tv[i], valid, rgb, tval[i], te[i]);
        end
        $display("clip (%0d,%0d) valid=%b rgb=%h", th[i], tv[i], valid, rgb);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    bit seen = 1'b0;
    cfg_write(0, 1'b1, 0, 0, 0);
    wait_fs();
    wait_out(1, 0, ok);
    if (ok) begin
      checks++;
      if (rgb !== 12'd1) begin
        errors++; $display("FAIL pre_reset (1,0) rgb got %h want 001", rgb);
      end
    end
    wait_out(20, 10, ok);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({valid, hsync, vsync, rgb, h_cnt, v_cnt, rom_addr} !== {1'b0, 1'b1, 1'b1, 12'h0, 10'd0, 10'd0, 12'h0}) begin
      errors++;
      $display("FAIL async_reset valid=%b hs=%b vs=%b rgb=%h h=%0d v=%0d addr=%0d want 0 1 1 000 0 0 0",
               valid, hsync, vsync, rgb, h_cnt, v_cnt, rom_addr);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || h_cnt !== 10'd0 || v_cnt !== 10'd0) begin
      errors++; $display("FAIL first_valid seen=%b at (%0d,%0d) want (0,0)", seen, h_cnt, v_cnt);
    end
    $display("after reset first valid pixel (%0d,%0d)", h_cnt, v_cnt);
    wait_out(1, 0, ok);
    if (ok) begin
      checks++;
      if (rgb !== 12'd0) begin
        errors++; $display("FAIL cfg_cleared (1,0) rgb got %h want 000", rgb);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) rom_mem[a] = CW'(a);
    rst = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_en = 1'b0;
    cfg_x = '0; cfg_y = '0; cfg_base = '0;
    test_reset();
    test_timing();
    test_single();
    test_shadow();
    test_priority();
    test_clip();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sprite_engine.md
# vga_sprite_engine

Parametrised successor to the fixed 640x480 address-generator/VGA-controller pair. It generates VGA timing from the system clock and composites up to `N_SPRITES` independently positioned sprites over a background colour. Sprites are fetched from one shared synchronous image ROM, time-multiplexed within each pixel period. It sits between game-state logic, which writes sprite position and enable over a config port, and the board VGA pins.

## Interface
**Parameters**
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16; `H_SYNC`, default 96; `H_BP`, default 48: horizontal porches and sync width, in pixels.
- `V_ACTIVE`, default 480: visible lines.
- `V_FP`, default 10; `V_SYNC`, default 2; `V_BP`, default 33: vertical porches and sync width, in lines.
- `PIX_DIV`, default 4: `clk` cycles per pixel. Must be ≥ `N_SPRITES`+1.
- `N_SPRITES`, default 3: number of sprite channels, 1..`PIX_DIV`-1.
- `SPR_W`, default 64; `SPR_H`, default 64: sprite size in pixels.
- `ADDR_W`, default 17: ROM address width.
- `COLOR_W`, default 12: RGB width.
- `BG_COLOR`, default 12'h000: background colour.
- `KEY_COLOR`, default 12'hF0F: transparent colour.

**Ports**
- `clk`, in, 1: system clock, 100 MHz.
- `rst`, in, 1: reset, asynchronous, active-low.
- `cfg_we`, in, 1: config write strobe.
- `cfg_sel`, in, `$clog2(N_SPRITES)`: sprite index. Values ≥ `N_SPRITES` are ignored.
- `cfg_en`, in, 1: sprite enable.
- `cfg_x`, in, 10: sprite left column.
- `cfg_y`, in, 10: sprite top line.
- `cfg_base`, in, `ADDR_W`: ROM address of sprite pixel (0,0).
- `rom_addr`, out, `ADDR_W`: ROM read address. Data is returned 1 `clk` later.
- `rom_data`, in, `COLOR_W`: ROM read data.
- `rgb`, out, `COLOR_W`: pixel colour. Forced to 0 when `valid`=0.
- `hsync`, out, 1; `vsync`, out, 1: sync outputs, active-low.
- `valid`, out, 1: active-region flag.
- `h_cnt`, out, 10; `v_cnt`, out, 10: coordinates of the pixel currently on `rgb`.
- `frame_start`, out, 1: one-`clk` pulse when shadow registers load.

## Operation
- **Slot counter.** Slot counter `s` cycles 0..`PIX_DIV`-1. Pixel enable `pe` is asserted when `s`=`PIX_DIV`-1. Internal counters `hc`/`vc` advance on `pe`.
  - `hc` wraps at H_TOTAL = `H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP`; on wrap, `vc` increments.
  - `vc` wraps at V_TOTAL, computed the same way from the vertical parameters.
- **Hit test.** In slot `s` < `N_SPRITES`, sprite `s` "hits" when all of the following hold, compared in 11-bit unsigned arithmetic:
  - en=1;
  - x ≤ `hc` < x+`SPR_W`;
  - y ≤ `vc` < y+`SPR_H`.
- **ROM fetch.** On a hit, `rom_addr` = base + (`vc`-y)*`SPR_W` + (`hc`-x), truncated to `ADDR_W`. On a miss, `rom_addr` holds its previous value.
- **Clipping.** A sprite extending past `H_ACTIVE` or `V_ACTIVE` is clipped. Coordinates never wrap.
- **Compositing.**
  - The accumulator resets to `BG_COLOR` at slot 0.
  - In slot `s`+1, `rom_data` for sprite `s` is examined. If sprite `s` hit, `rom_data` ≠ `KEY_COLOR`, and no lower-index sprite has already won, `rom_data` is taken.
  - Index 0 has the highest priority.
- **Output register.** On `pe`, the following load together:
  - `rgb` ← accumulator, or 0 if not active;
  - `valid`, `hsync`, `vsync`, `h_cnt`, `v_cnt` ← values for the pixel just composed.
- **Config shadowing.**
  - `cfg_we` writes the pending registers of sprite `cfg_sel` on any cycle.
  - Pending registers copy to active on the `pe` where (`hc`,`vc`) becomes (0,`V_ACTIVE`). `frame_start` pulses on that same cycle.
  - A `cfg_we` on the copy cycle updates pending only; active receives the pre-write value.
- **Sync timing.**
  - `hsync`=0 for `hc` in [`H_ACTIVE`+`H_FP`, `H_ACTIVE`+`H_FP`+`H_SYNC`).
  - `vsync`=0 for `vc` in the analogous vertical range.
  - Both outputs are otherwise 1.

## Timing
- **Reset values.**
  - `s`=0, `hc`=`vc`=0.
  - `rgb`=0, `valid`=0, `hsync`=1, `vsync`=1, `h_cnt`=`v_cnt`=0, `rom_addr`=0, `frame_start`=0.
  - All pending and active sprite registers = 0 (disabled).
- **Reset mid-frame.** Outputs return to reset values immediately (asynchronous). Output resumes from pixel (0,0) after `rst` releases.
- **Latency.** Output is delayed exactly one pixel period (`PIX_DIV` clks) from the `hc`/`vc` sample. All outputs are mutually aligned.
- **Update rate.** Outputs change only on `pe` cycles. `frame_start` changes on the copy cycle.
- **Throughput.** One pixel per `PIX_DIV` clks, sustained with no stalls.

## Structure
- Shared package `vga_pkg`:
  - default 640x480 timing constants;
  - `COLOR_W`, `BG_COLOR`, `KEY_COLOR`;
  - `sprite_cfg_t` struct {en, x, y, base}.
- One natural sub-module: `vga_timing`, containing the slot/pixel divider, `hc`/`vc`, sync/valid decode, and the frame-start strobe.
- The sprite register file and compositor stay in the top module.

## Test plan
- **Reset and timing.** Hold `rst`=0 → `hsync`=`vsync`=1, `rgb`=0. Release → `hsync` low for 96 pixels (384 clk) per 800-pixel line. `vsync` low for 2 lines per 525. `valid` high for 640×480 pixels.
- **Single sprite.** Sprite 0 en=1, x=100, y=50, base=0; ROM returns addr[11:0] → pixel (100,50) = 12'h000; pixel (163,50) = 63; pixel (100,51) = 64; pixel (164,50) = `BG_COLOR`.
- **Priority and transparency.** Sprites 0 and 1 overlap at (200,200); sprite 0 data = 12'hF0F and sprite 1 data = 12'h0A0 → output 12'h0A0. With sprite 0 data = 12'h123 → output 12'h123.
- **Shadowing.** Write x=300 for sprite 0 at v=100 → no change in the current frame. `frame_start` pulses at (0,480). The next frame draws at x=300. A write on the copy cycle takes effect one frame later.
- **Clipping.** x=620 → columns 620..639 drawn, no wrap to column 0 of the next line.
- **Async reset.** Async reset asserted at (320,240) → outputs reset within the same cycle. After release, first `valid`=1 pixel is (0,0).
